// File: rtl/mem_read_arbiter.sv
// mem_read_arbiter
//   Read-channel arbiter and address router between the core's two read
//   masters (m0 = IFU, m1 = LSU) and its two read slaves (s0 = CLINT,
//   s1 = main-memory bridge). Only one read is in flight at a time.
//   Masters are granted round-robin. The latched address selects the slave.
//   An address-phase watchdog turns a slave that never accepts into an
//   error response to the master.
//
// Parameters:
//   CLINT_BASE, CLINT_SIZE  byte window routed to s0; everything else goes to s1
//   TIMEOUT                 max ADDR cycles without raddr_ready; 0 disables it
//
// Ports:
//   clk, rst                                   clock, synchronous active-high reset
//   mN_raddr, mN_rsize, mN_raddr_valid (in)    master N request
//   mN_raddr_ready (out)                       master N request accepted
//   mN_rdata, mN_rerr, mN_rdata_valid (out)    master N response
//   mN_rdata_ready (in)                        master N response accepted
//   sN_raddr, sN_rsize, sN_raddr_valid (out)   slave N address phase
//   sN_raddr_ready (in)                        slave N address accepted
//   sN_rdata, sN_rdata_valid (in)              slave N data phase
//   sN_rdata_ready (out)                       slave N data accepted
module mem_read_arbiter #(
  parameter logic [31:0] CLINT_BASE = 32'h0200_0000,
  parameter logic [31:0] CLINT_SIZE = 32'h0001_0000,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        rst,
  // IFU
  input  logic [31:0] m0_raddr,
  input  logic [2:0]  m0_rsize,
  input  logic        m0_raddr_valid,
  output logic        m0_raddr_ready,
  output logic [63:0] m0_rdata,
  output logic        m0_rerr,
  output logic        m0_rdata_valid,
  input  logic        m0_rdata_ready,
  // LSU
  input  logic [31:0] m1_raddr,
  input  logic [2:0]  m1_rsize,
  input  logic        m1_raddr_valid,
  output logic        m1_raddr_ready,
  output logic [63:0] m1_rdata,
  output logic        m1_rerr,
  output logic        m1_rdata_valid,
  input  logic        m1_rdata_ready,
  // CLINT
  output logic [31:0] s0_raddr,
  output logic [2:0]  s0_rsize,
  output logic        s0_raddr_valid,
  input  logic        s0_raddr_ready,
  input  logic [63:0] s0_rdata,
  input  logic        s0_rdata_valid,
  output logic        s0_rdata_ready,
  // memory bridge
  output logic [31:0] s1_raddr,
  output logic [2:0]  s1_rsize,
  output logic        s1_raddr_valid,
  input  logic        s1_raddr_ready,
  input  logic [63:0] s1_rdata,
  input  logic        s1_rdata_valid,
  output logic        s1_rdata_ready
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, ERR} state_t;

  state_t      state;
  state_t      state_next;

  logic        last;
  logic        gnt;
  logic        sel;
  logic [31:0] addr_q;
  logic [2:0]  size_q;
  logic [31:0] wd_cnt;

  logic        any_req;
  logic        grant_id;
  logic [31:0] req_addr;
  logic [2:0]  req_size;
  logic        req_is_clint;
  logic [32:0] addr_ext;
  logic [32:0] win_lo;
  logic [32:0] win_hi;

  logic        sel_raddr_ready;
  logic        sel_rdata_valid;
  logic [63:0] sel_rdata;
  logic        gnt_rdata_ready;
  logic        timeout_hit;
  logic        txn_done;

  // With both masters requesting, the one that did not complete last wins;
  // otherwise the single requester is granted.
  assign any_req  = m0_raddr_valid | m1_raddr_valid;
  assign grant_id = (m0_raddr_valid && m1_raddr_valid) ? ~last : m1_raddr_valid;
  assign req_addr = grant_id ? m1_raddr : m0_raddr;
  assign req_size = grant_id ? m1_rsize : m0_rsize;

  // Window compare is 33 bits wide so CLINT_BASE + CLINT_SIZE cannot wrap.
  assign addr_ext     = {1'b0, req_addr};
  assign win_lo       = {1'b0, CLINT_BASE};
  assign win_hi       = {1'b0, CLINT_BASE} + {1'b0, CLINT_SIZE};
  assign req_is_clint = (addr_ext >= win_lo) && (addr_ext < win_hi);

  assign sel_raddr_ready = sel ? s1_raddr_ready : s0_raddr_ready;
  assign sel_rdata_valid = sel ? s1_rdata_valid : s0_rdata_valid;
  assign sel_rdata       = sel ? s1_rdata       : s0_rdata;
  assign gnt_rdata_ready = gnt ? m1_rdata_ready : m0_rdata_ready;

  // wd_cnt holds the number of ADDR cycles already spent without a handshake.
  // The cycle where it equals TIMEOUT-1 is the last one allowed.
  assign timeout_hit = (TIMEOUT != 0) && (wd_cnt == TIMEOUT - 1);

  assign txn_done = ((state == DATA) && sel_rdata_valid && gnt_rdata_ready) ||
                    ((state == ERR) && gnt_rdata_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (any_req) state_next = ADDR;
      ADDR: begin
        if (sel_raddr_ready) begin
          state_next = DATA;
        end else if (timeout_hit) begin
          state_next = ERR;
        end
      end
      DATA: if (sel_rdata_valid && gnt_rdata_ready) state_next = IDLE;
      ERR:  if (gnt_rdata_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The request is captured on the accept cycle. last is updated only when a
  // transaction completes, so an abandoned (reset) read does not count.
  always_ff @(posedge clk) begin
    if (rst) begin
      last   <= 1'b1;
      gnt    <= 1'b0;
      sel    <= 1'b0;
      addr_q <= '0;
      size_q <= '0;
      wd_cnt <= '0;
    end else begin
      if (state == IDLE && any_req) begin
        gnt    <= grant_id;
        sel    <= ~req_is_clint;
        addr_q <= req_addr;
        size_q <= req_size;
      end
      if (state == ADDR && state_next == ADDR) begin
        wd_cnt <= wd_cnt + 32'd1;
      end else begin
        wd_cnt <= '0;
      end
      if (txn_done) begin
        last <= gnt;
      end
    end
  end

  // Everything defaults to 0 so that unselected ports stay quiet. Reset also
  // forces the outputs low, including the combinational accept/data paths.
  always_comb begin
    m0_raddr_ready = 1'b0;
    m0_rdata       = '0;
    m0_rerr        = 1'b0;
    m0_rdata_valid = 1'b0;
    m1_raddr_ready = 1'b0;
    m1_rdata       = '0;
    m1_rerr        = 1'b0;
    m1_rdata_valid = 1'b0;
    s0_raddr       = '0;
    s0_rsize       = '0;
    s0_raddr_valid = 1'b0;
    s0_rdata_ready = 1'b0;
    s1_raddr       = '0;
    s1_rsize       = '0;
    s1_raddr_valid = 1'b0;
    s1_rdata_ready = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          m0_raddr_ready = any_req && !grant_id;
          m1_raddr_ready = any_req && grant_id;
        end
        ADDR: begin
          if (sel) begin
            s1_raddr       = addr_q;
            s1_rsize       = size_q;
            s1_raddr_valid = 1'b1;
          end else begin
            s0_raddr       = addr_q;
            s0_rsize       = size_q;
            s0_raddr_valid = 1'b1;
          end
        end
        DATA: begin
          if (sel) begin
            s1_rdata_ready = gnt_rdata_ready;
          end else begin
            s0_rdata_ready = gnt_rdata_ready;
          end
          if (gnt) begin
            m1_rdata_valid = sel_rdata_valid;
            m1_rdata       = sel_rdata_valid ? sel_rdata : '0;
          end else begin
            m0_rdata_valid = sel_rdata_valid;
            m0_rdata       = sel_rdata_valid ? sel_rdata : '0;
          end
        end
        ERR: begin
          if (gnt) begin
            m1_rdata_valid = 1'b1;
            m1_rerr        = 1'b1;
          end else begin
            m0_rdata_valid = 1'b1;
            m0_rerr        = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_read_arbiter.sv
// tb_mem_read_arbiter
//   Self-checking bench for mem_read_arbiter. Directed scenarios followed by
//   randomized batches. A transaction-level model predicts every DUT output
//   each cycle. Literal checks pin the directed scenarios.
module tb_mem_read_arbiter;

  localparam int unsigned TIMEOUT    = 6;
  localparam logic [31:0] CLINT_BASE = 32'h0200_0000;
  localparam logic [31:0] CLINT_SIZE = 32'h0001_0000;

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  size;
  } req_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [31:0] m_raddr       [2];
  logic [2:0]  m_rsize       [2];
  logic        m_raddr_valid [2];
  logic        m_raddr_ready [2];
  logic [63:0] m_rdata       [2];
  logic        m_rerr        [2];
  logic        m_rdata_valid [2];
  logic        m_rdata_ready [2];
  logic [31:0] s_raddr       [2];
  logic [2:0]  s_rsize       [2];
  logic        s_raddr_valid [2];
  logic        s_raddr_ready [2];
  logic [63:0] s_rdata       [2];
  logic        s_rdata_valid [2];
  logic        s_rdata_ready [2];

  int vectors    = 0;
  int miscompares = 0;
  int cycle      = 0;

  // Stimulus knobs: s_rdy_delay -1 random, -2 never, N ready after N waits.
  // s_dv_mode 0 random, 1 always, 2 never. m_rdy_delay -1 random, N waits.
  int          s_rdy_delay  [2] = '{0, 0};
  int          s_dv_mode    [2] = '{1, 1};
  logic [63:0] s_fixed_data [2] = '{64'h0, 64'h0};
  int          m_rdy_delay  [2] = '{0, 0};

  req_t req_q0[$];
  req_t req_q1[$];

  int s_valid_seen  [2] = '{0, 0};
  int m_valid_seen  [2] = '{0, 0};
  int s_valid_total [2] = '{0, 0};

  int          grant_log[$];
  int          accept_cycle[$];
  int          slave_log[$];
  logic [63:0] data_log_data[$];
  logic        data_log_err[$];
  int          data_log_master[$];
  int          data_cycle[$];

  // Transaction-level reference state.
  bit          mdl_busy;
  bit          mdl_addr_done;
  bit          mdl_err;
  int          mdl_master;
  int          mdl_slave;
  int          mdl_wait;
  int          mdl_last;
  logic [31:0] mdl_addr;
  logic [2:0]  mdl_size;

  mem_read_arbiter #(
    .CLINT_BASE(CLINT_BASE),
    .CLINT_SIZE(CLINT_SIZE),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .m0_raddr(m_raddr[0]), .m0_rsize(m_rsize[0]),
    .m0_raddr_valid(m_raddr_valid[0]), .m0_raddr_ready(m_raddr_ready[0]),
    .m0_rdata(m_rdata[0]), .m0_rerr(m_rerr[0]),
    .m0_rdata_valid(m_rdata_valid[0]), .m0_rdata_ready(m_rdata_ready[0]),
    .m1_raddr(m_raddr[1]), .m1_rsize(m_rsize[1]),
    .m1_raddr_valid(m_raddr_valid[1]), .m1_raddr_ready(m_raddr_ready[1]),
    .m1_rdata(m_rdata[1]), .m1_rerr(m_rerr[1]),
    .m1_rdata_valid(m_rdata_valid[1]), .m1_rdata_ready(m_rdata_ready[1]),
    .s0_raddr(s_raddr[0]), .s0_rsize(s_rsize[0]),
    .s0_raddr_valid(s_raddr_valid[0]), .s0_raddr_ready(s_raddr_ready[0]),
    .s0_rdata(s_rdata[0]), .s0_rdata_valid(s_rdata_valid[0]),
    .s0_rdata_ready(s_rdata_ready[0]),
    .s1_raddr(s_raddr[1]), .s1_rsize(s_rsize[1]),
    .s1_raddr_valid(s_raddr_valid[1]), .s1_raddr_ready(s_raddr_ready[1]),
    .s1_rdata(s_rdata[1]), .s1_rdata_valid(s_rdata_valid[1]),
    .s1_rdata_ready(s_rdata_ready[1])
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Drive all DUT inputs for the coming cycle from the request queues and knobs.
  task automatic applyStimulus();
    req_t r;
    bit   have;
    for (int i = 0; i < 2; i++) begin
      have = (i == 0) ? (req_q0.size() > 0) : (req_q1.size() > 0);
      r.addr = 32'h0;
      r.size = 3'h0;
      if (have) r = (i == 0) ? req_q0[0] : req_q1[0];
      m_raddr_valid[i] = have;
      m_raddr[i]       = r.addr;
      m_rsize[i]       = r.size;
      if (m_rdy_delay[i] < 0) m_rdata_ready[i] = ($urandom_range(0, 9) < 6);
      else                    m_rdata_ready[i] = (m_valid_seen[i] >= m_rdy_delay[i]);
    end
    for (int j = 0; j < 2; j++) begin
      if (s_rdy_delay[j] == -1)      s_raddr_ready[j] = ($urandom_range(0, 9) < 7);
      else if (s_rdy_delay[j] == -2) s_raddr_ready[j] = 1'b0;
      else s_raddr_ready[j] = s_raddr_valid[j] && (s_valid_seen[j] >= s_rdy_delay[j]);
      case (s_dv_mode[j])
        0: begin
          s_rdata_valid[j] = ($urandom_range(0, 1) == 1);
          s_rdata[j]       = {$urandom, $urandom};
        end
        1: begin
          s_rdata_valid[j] = 1'b1;
          s_rdata[j]       = s_fixed_data[j];
        end
        default: begin
          s_rdata_valid[j] = 1'b0;
          s_rdata[j]       = s_fixed_data[j];
        end
      endcase
    end
  endtask

  // Record handshakes seen this cycle (bench-side bookkeeping only).
  task automatic observe();
    for (int i = 0; i < 2; i++) begin
      if (m_raddr_valid[i] && m_raddr_ready[i]) begin
        grant_log.push_back(i);
        accept_cycle.push_back(cycle);
        if (i == 0) void'(req_q0.pop_front());
        else        void'(req_q1.pop_front());
      end
      if (m_rdata_valid[i]) begin
        if (m_rdata_ready[i]) begin
          data_log_data.push_back(m_rdata[i]);
          data_log_err.push_back(m_rerr[i]);
          data_log_master.push_back(i);
          data_cycle.push_back(cycle);
          m_valid_seen[i] = 0;
        end else begin
          m_valid_seen[i]++;
        end
      end
    end
    for (int j = 0; j < 2; j++) begin
      if (s_raddr_valid[j]) begin
        s_valid_total[j]++;
        if (s_raddr_ready[j]) begin
          slave_log.push_back(j);
          s_valid_seen[j] = 0;
        end else begin
          s_valid_seen[j]++;
        end
      end
    end
  endtask

  initial begin : driver
    applyStimulus();
    forever begin
      @(negedge clk);
      applyStimulus();
      #1;
      observe();
    end
  end

  task automatic modelReset();
    mdl_busy      = 1'b0;
    mdl_addr_done = 1'b0;
    mdl_err       = 1'b0;
    mdl_master    = 0;
    mdl_slave     = 0;
    mdl_wait      = 0;
    mdl_last      = 1;
    mdl_addr      = '0;
    mdl_size      = '0;
  endtask

  // One cycle of the reference: predict outputs, compare, then advance.
  task automatic modelCycle();
    logic        e_m_raddr_ready [2];
    logic [63:0] e_m_rdata       [2];
    logic        e_m_rerr        [2];
    logic        e_m_rdata_valid [2];
    logic [31:0] e_s_raddr       [2];
    logic [2:0]  e_s_rsize       [2];
    logic        e_s_raddr_valid [2];
    logic        e_s_rdata_ready [2];
    bit          any;
    int          g;
    for (int k = 0; k < 2; k++) begin
      e_m_raddr_ready[k] = 0; e_m_rdata[k] = '0; e_m_rerr[k] = 0; e_m_rdata_valid[k] = 0;
      e_s_raddr[k] = '0; e_s_rsize[k] = '0; e_s_raddr_valid[k] = 0; e_s_rdata_ready[k] = 0;
    end
    any = m_raddr_valid[0] || m_raddr_valid[1];
    if (m_raddr_valid[0] && m_raddr_valid[1]) g = 1 - mdl_last;
    else                                      g = m_raddr_valid[0] ? 0 : 1;

    if (!rst) begin
      if (!mdl_busy) begin
        if (any) e_m_raddr_ready[g] = 1'b1;
      end else if (mdl_err) begin
        e_m_rdata_valid[mdl_master] = 1'b1;
        e_m_rerr[mdl_master]        = 1'b1;
      end else if (!mdl_addr_done) begin
        e_s_raddr_valid[mdl_slave] = 1'b1;
        e_s_raddr[mdl_slave]       = mdl_addr;
        e_s_rsize[mdl_slave]       = mdl_size;
      end else begin
        e_s_rdata_ready[mdl_slave]  = m_rdata_ready[mdl_master];
        e_m_rdata_valid[mdl_master] = s_rdata_valid[mdl_slave];
        if (s_rdata_valid[mdl_slave]) e_m_rdata[mdl_master] = s_rdata[mdl_slave];
      end
    end

    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("m%0d_raddr_ready", k), m_raddr_ready[k], e_m_raddr_ready[k]);
      checkOutput($sformatf("m%0d_rdata", k),       m_rdata[k],       e_m_rdata[k]);
      checkOutput($sformatf("m%0d_rerr", k),        m_rerr[k],        e_m_rerr[k]);
      checkOutput($sformatf("m%0d_rdata_valid", k), m_rdata_valid[k], e_m_rdata_valid[k]);
      checkOutput($sformatf("s%0d_raddr", k),       s_raddr[k],       e_s_raddr[k]);
      checkOutput($sformatf("s%0d_rsize", k),       s_rsize[k],       e_s_rsize[k]);
      checkOutput($sformatf("s%0d_raddr_valid", k), s_raddr_valid[k], e_s_raddr_valid[k]);
      checkOutput($sformatf("s%0d_rdata_ready", k), s_rdata_ready[k], e_s_rdata_ready[k]);
    end

    if (rst) begin
      modelReset();
    end else if (!mdl_busy) begin
      if (any) begin
        mdl_busy      = 1'b1;
        mdl_addr_done = 1'b0;
        mdl_err       = 1'b0;
        mdl_wait      = 0;
        mdl_master    = g;
        mdl_addr      = m_raddr[g];
        mdl_size      = m_rsize[g];
        // Offset from the window base is below the size only inside the window.
        mdl_slave     = ((m_raddr[g] - CLINT_BASE) < CLINT_SIZE) ? 0 : 1;
      end
    end else if (mdl_err) begin
      if (m_rdata_ready[mdl_master]) begin
        mdl_busy = 1'b0;
        mdl_last = mdl_master;
      end
    end else if (!mdl_addr_done) begin
      if (s_raddr_ready[mdl_slave]) begin
        mdl_addr_done = 1'b1;
      end else begin
        mdl_wait++;
        if (TIMEOUT != 0 && mdl_wait == int'(TIMEOUT)) mdl_err = 1'b1;
      end
    end else if (s_rdata_valid[mdl_slave] && m_rdata_ready[mdl_master]) begin
      mdl_busy = 1'b0;
      mdl_last = mdl_master;
    end
  endtask

  initial begin : compare
    modelReset();
    forever begin
      @(negedge clk);
      #1;
      modelCycle();
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic setSlave(input int j, input int dly, input int dv, input logic [63:0] d);
    s_rdy_delay[j]  = dly;
    s_dv_mode[j]    = dv;
    s_fixed_data[j] = d;
  endtask

  task automatic pushReq(input int i, input logic [31:0] a, input logic [2:0] sz);
    req_t r;
    r.addr = a;
    r.size = sz;
    if (i == 0) req_q0.push_back(r);
    else        req_q1.push_back(r);
  endtask

  task automatic clearLogs();
    grant_log.delete(); accept_cycle.delete(); slave_log.delete();
    data_log_data.delete(); data_log_err.delete(); data_log_master.delete();
    data_cycle.delete();
    s_valid_total = '{0, 0};
  endtask

  task automatic waitDone(input string name, input int budget);
    int k;
    k = 0;
    step(1);
    while ((req_q0.size() > 0 || req_q1.size() > 0 || mdl_busy) && k < budget) begin
      step(1);
      k++;
    end
    if (k >= budget) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL %s: wait expired after %0d cycles, transaction still pending", name, budget);
      req_q0.delete();
      req_q1.delete();
    end
  endtask

  function automatic logic [31:0] randAddr();
    logic [31:0] a;
    case ($urandom_range(0, 7))
      0: a = CLINT_BASE;
      1: a = CLINT_BASE + CLINT_SIZE - 32'd1;
      2: a = CLINT_BASE + CLINT_SIZE;
      3: a = CLINT_BASE - 32'd1;
      4: a = CLINT_BASE + ($urandom & 32'h0000_FFF8);
      5: a = 32'hFFFF_FFFF;
      6: a = 32'h0000_0000;
      default: a = $urandom;
    endcase
    return a;
  endfunction

  function automatic int pickDelay();
    int r;
    r = int'($urandom_range(0, 9));
    if (r < 4)  return -1;
    if (r == 4) return -2;
    return r - 3;
  endfunction

  initial begin : script
    logic [31:0] dec_addr [4];
    int          dec_exp  [4];
    int          gnt_exp  [6];
    int          n0;
    int          n1;
    int          k;
    dec_addr = '{32'h0200_0000, 32'h0200_FFFF, 32'h0201_0000, 32'h01FF_FFFF};
    dec_exp  = '{0, 0, 1, 1};
    gnt_exp  = '{0, 1, 0, 1, 0, 1};

    // Single read, with the request already pending while reset is held.
    $display("[TB] single read");
    setSlave(0, 0, 1, 64'h0);
    setSlave(1, 0, 1, 64'hDEAD_BEEF_0000_0001);
    m_rdy_delay = '{0, 0};
    step(1);
    pushReq(0, 32'h8000_0000, 3'd2);
    step(1);
    checkOutput("reset.m0_raddr_ready", m_raddr_ready[0], 1'b0);
    checkOutput("reset.s1_raddr_valid", s_raddr_valid[1], 1'b0);
    rst = 1'b0;
    waitDone("single", 50);
    checkOutput("single.count", data_log_data.size(), 1);
    checkOutput("single.data", data_log_data[0], 64'hDEAD_BEEF_0000_0001);
    checkOutput("single.rerr", data_log_err[0], 1'b0);
    checkOutput("single.latency", data_cycle[0] - accept_cycle[0], 2);
    checkOutput("single.s0_untouched", s_valid_total[0], 0);

    // CLINT window edges.
    $display("[TB] decode boundaries");
    clearLogs();
    for (int i = 0; i < 4; i++) pushReq(1, dec_addr[i], 3'd3);
    waitDone("decode", 100);
    checkOutput("decode.count", slave_log.size(), 4);
    for (int i = 0; i < 4; i++)
      checkOutput($sformatf("decode.route%0d", i),
                  (i < slave_log.size()) ? slave_log[i] : 99, dec_exp[i]);

    // Continuous contention alternates, starting with m0 after an m1 completion.
    $display("[TB] contention");
    clearLogs();
    for (int i = 0; i < 3; i++) begin
      pushReq(0, 32'h8000_0100 + 32'(i * 8), 3'd3);
      pushReq(1, 32'h8000_0200 + 32'(i * 8), 3'd3);
    end
    waitDone("contention", 100);
    checkOutput("contention.count", grant_log.size(), 6);
    for (int i = 0; i < 6; i++)
      checkOutput($sformatf("contention.grant%0d", i),
                  (i < grant_log.size()) ? grant_log[i] : 99, gnt_exp[i]);

    // Slave accepts on the last cycle the watchdog allows; master stalls data.
    $display("[TB] backpressure");
    clearLogs();
    setSlave(1, 5, 1, 64'h0123_4567_89AB_CDEF);
    m_rdy_delay = '{3, 0};
    pushReq(0, 32'h8000_1000, 3'd3);
    waitDone("backpressure", 100);
    checkOutput("backpressure.count", data_log_data.size(), 1);
    checkOutput("backpressure.data", data_log_data[0], 64'h0123_4567_89AB_CDEF);
    checkOutput("backpressure.addr_hs", slave_log.size(), 1);
    checkOutput("backpressure.addr_cycles", s_valid_total[1], TIMEOUT);

    // Slave never accepts: error response, then a normal read.
    $display("[TB] watchdog");
    clearLogs();
    setSlave(1, -2, 1, 64'h0);
    m_rdy_delay = '{0, 0};
    pushReq(1, 32'h9000_0000, 3'd2);
    waitDone("watchdog", 100);
    checkOutput("watchdog.addr_cycles", s_valid_total[1], TIMEOUT);
    checkOutput("watchdog.addr_hs", slave_log.size(), 0);
    checkOutput("watchdog.rerr", data_log_err[0], 1'b1);
    checkOutput("watchdog.rdata", data_log_data[0], 64'h0);
    checkOutput("watchdog.master", data_log_master[0], 1);
    checkOutput("watchdog.latency", data_cycle[0] - accept_cycle[0], TIMEOUT + 1);
    setSlave(1, 0, 1, 64'h1111_2222_3333_4444);
    pushReq(1, 32'h9000_0008, 3'd2);
    waitDone("watchdog_next", 100);
    checkOutput("watchdog_next.data", data_log_data[1], 64'h1111_2222_3333_4444);
    checkOutput("watchdog_next.rerr", data_log_err[1], 1'b0);

    // m0 completes last, then an m0 CLINT read is reset while waiting for data.
    $display("[TB] reset mid-data");
    pushReq(0, 32'h8000_2000, 3'd3);
    waitDone("pre_reset", 50);
    clearLogs();
    setSlave(0, 0, 2, 64'h0BAD_0BAD_0BAD_0BAD);
    pushReq(0, 32'h0200_0040, 3'd3);
    k = 0;
    while (slave_log.size() == 0 && k < 50) begin
      step(1);
      k++;
    end
    checkOutput("rst.reached_data", slave_log.size(), 1);
    rst = 1'b1;
    step(1);
    s_valid_seen = '{0, 0};
    m_valid_seen = '{0, 0};
    rst = 1'b0;
    setSlave(0, 0, 1, 64'h0BAD_0BAD_0BAD_0BAD);
    step(2);
    checkOutput("rst.no_response", data_log_data.size(), 0);
    pushReq(0, 32'h8000_3000, 3'd3);
    pushReq(1, 32'h8000_3008, 3'd3);
    waitDone("post_reset", 50);
    checkOutput("rst.first_grant", (grant_log.size() > 1) ? grant_log[1] : 99, 0);

    // Randomized batches.
    $display("[TB] random batches");
    for (int b = 0; b < 40; b++) begin
      for (int j = 0; j < 2; j++)
        setSlave(j, pickDelay(), ($urandom_range(0, 3) == 0) ? 1 : 0, {$urandom, $urandom});
      for (int i = 0; i < 2; i++)
        m_rdy_delay[i] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3)) : -1;
      n0 = int'($urandom_range(0, 4));
      n1 = int'($urandom_range(0, 4));
      for (int i = 0; i < n0; i++) pushReq(0, randAddr(), 3'($urandom_range(0, 7)));
      for (int i = 0; i < n1; i++) pushReq(1, randAddr(), 3'($urandom_range(0, 7)));
      waitDone($sformatf("random%0d", b), 3000);
    end

    step(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
